latch_write_ctrl: RTL and testbench

Clocked write-side controller for a bank of level-sensitive transparent D latches. It accepts a data word over a valid/ready handshake and drives the bank's `lat_D`/`lat_En` pins with a glitch-free setup → enable-pulse → hold sequence, so the latch captures cleanly. It then signals completion. It sits between synchronous logic and any latch-based storage or hold register in the design; optionally it reads the latch output back and flags mismatches.

---
 rtl/latch_ctrl_pkg.sv | 28 ++
 rtl/latch_phase_cnt.sv | 28 ++
 rtl/latch_write_ctrl.sv | 148 ++++++++++++++
 tb/tb_latch_write_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write controller: state encodings and
// the phase-counter width helper.
package latch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    PULSE = ST_PULSE,
    HOLD  = ST_HOLD,
    CHECK = ST_CHECK
  } state_t;

  // Width needed to hold the largest (phase length - 1), plus one spare bit.
  function automatic int cnt_width(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/latch_phase_cnt.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
// Saturates at zero; zero flag is decoded from the count.
module latch_phase_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Write-side controller for a transparent D-latch bank: accepts a word,
// then drives setup -> enable pulse -> hold on lat_D/lat_En and pulses done.
// Optional readback compare is compiled in with LATCH_READBACK_EN.
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] lat_D,
  output logic             lat_En,
  input  logic [WIDTH-1:0] lat_Q,
  output logic             done,
  output logic             err
);
  import latch_ctrl_pkg::*;

  localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "latch_write_ctrl: WIDTH must be >= 1");
  end
  if (SETUP_CYC < 1) begin : g_bad_setup
    $fatal(1, "latch_write_ctrl: SETUP_CYC must be >= 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $fatal(1, "latch_write_ctrl: PULSE_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $fatal(1, "latch_write_ctrl: HOLD_CYC must be >= 1");
  end

  state_t        state;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  latch_phase_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign in_ready = (state == IDLE);

  // Reload the phase counter on every phase entry.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(PULSE_CYC - 1);
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(HOLD_CYC - 1);
        end
      end
      default: ;
    endcase
  end

  // Sequencer: lat_D loads only on accept, lat_En is a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lat_D  <= '0;
      lat_En <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            lat_D <= in_data;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            lat_En <= 1'b1;
            state  <= PULSE;
          end
        end
        PULSE: begin
          if (cnt_zero) begin
            lat_En <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
`ifdef LATCH_READBACK_EN
            state <= CHECK;
`else
            state <= IDLE;
            done  <= 1'b1;
`endif
          end
        end
        CHECK: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LATCH_READBACK_EN
  logic err_flag;

  // Compare latch outputs with the written word during the CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
    end else begin
      err_flag <= (state == CHECK) && (lat_Q != lat_D);
    end
  end

  assign err = err_flag;
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_Q;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Bench for latch_write_ctrl: two instances (default timing and 3/1/4),
// each checked every cycle against a cycle-offset reference model.
module tb_latch_write_ctrl;
  localparam int W = 8;
`ifdef LATCH_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   in_valid;
  logic [W-1:0] in_data [2];
  logic [1:0]   in_ready, lat_en, done, err;
  logic [W-1:0] lat_d [2];
  logic [W-1:0] lat_q [2];

  // Reference model state
  int           s_c [2] = '{1, 3};
  int           p_c [2] = '{2, 1};
  int           h_c [2] = '{1, 4};
  bit           busy [2];
  bit           acc [2];
  int           off [2];
  logic [W-1:0] d_exp [2];
  logic [W-1:0] lq [2];
  bit           corrupt [2];
  logic         done_exp [2];
  logic         err_exp [2];

  int total = 0;
  int bad   = 0;

  assign lat_q[0] = corrupt[0] ? '0 : lq[0];
  assign lat_q[1] = corrupt[1] ? '0 : lq[1];

  latch_write_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .lat_D(lat_d[0]), .lat_En(lat_en[0]),
    .lat_Q(lat_q[0]), .done(done[0]), .err(err[0])
  );

  latch_write_ctrl #(
    .WIDTH(W), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .lat_D(lat_d[1]), .lat_En(lat_en[1]),
    .lat_Q(lat_q[1]), .done(done[1]), .err(err[1])
  );

  function automatic logic en_exp(input int k);
    return busy[k] && off[k] >= s_c[k] && off[k] < s_c[k] + p_c[k];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k]     = 1'b0;
      off[k]      = 0;
      d_exp[k]    = '0;
      done_exp[k] = 1'b0;
      err_exp[k]  = 1'b0;
    end
  endtask

  // Called at each rising edge with inputs stable.
  task automatic model_edge(input int k);
    acc[k] = 1'b0;
    if (!rst_n) return;
    done_exp[k] = 1'b0;
    err_exp[k]  = 1'b0;
    if (!busy[k]) begin
      if (in_valid[k]) begin
        busy[k]  = 1'b1;
        acc[k]   = 1'b1;
        off[k]   = 0;
        d_exp[k] = in_data[k];
      end
    end else begin
      off[k]++;
      if (off[k] == s_c[k] + p_c[k] + h_c[k] + RB) begin
        busy[k]     = 1'b0;
        done_exp[k] = 1'b1;
        err_exp[k]  = (RB != 0) && (lat_q[k] !== d_exp[k]);
      end
    end
  endtask

  task automatic check(input int k);
    string n;
    n = (k == 0) ? "a" : "b";
    chk({n, ".in_ready"}, W'(in_ready[k]), W'(!busy[k]));
    chk({n, ".lat_D"},    lat_d[k],        d_exp[k]);
    chk({n, ".lat_En"},   W'(lat_en[k]),   W'(en_exp(k)));
    chk({n, ".done"},     W'(done[k]),     W'(done_exp[k]));
    chk({n, ".err"},      W'(err[k]),      W'(err_exp[k]));
    // Transparent latch: follows the written word while enabled.
    if (en_exp(k)) lq[k] = d_exp[k];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check(0);
    check(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int k, input logic [W-1:0] data);
    bit got;
    got = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = data;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = acc[k];
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL accept_timeout observed=0 expected=1 dut=%0d", k);
    end
    in_valid[k] = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    lq[0]      = '0;
    lq[1]      = '0;
    corrupt[0] = 1'b0;
    corrupt[1] = 1'b0;
    model_reset();
    #3;
    check(0);
    check(1);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Single write of A5 on default timing; latch must keep it afterwards.
    send(0, 8'hA5);
    run(6);
    chk("a.latch_hold_a5", lq[0], 8'hA5);

    // Continuous valid: C3 waits behind 3C and is taken in the done cycle.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h3C;
    cycle();
    in_data[0]  = 8'hC3;
    for (int i = 0; i < 20 && d_exp[0] != 8'hC3; i++) cycle();
    chk("a.second_word", d_exp[0], 8'hC3);
    in_valid[0] = 1'b0;
    run(6);

    // Reset during the enable pulse aborts the word without done.
    send(0, 8'h5A);
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check(0);
    check(1);
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    run(8);
    chk("a.latch_after_reset", lq[0], 8'h5A);

    // Stretched timing instance.
    send(1, 8'h96);
    run(10);
    chk("b.latch_hold_96", lq[1], 8'h96);

    // Readback mismatch then match (err only reported in readback builds).
    corrupt[0] = 1'b1;
    send(0, 8'hFF);
    run(7);
    corrupt[0] = 1'b0;
    send(0, 8'hFF);
    run(7);

    // Randomized traffic on both instances.
    for (int t = 0; t < 40; t++) begin
      int k;
      k = int'($urandom_range(0, 1));
      corrupt[k] = ($urandom_range(0, 3) == 0);
      send(k, W'($urandom));
      run(int'($urandom_range(0, 12)));
      corrupt[k] = 1'b0;
    end
    run(12);

    // Idle: everything static.
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
